// File: rtl/imem_prog_if.sv
// Fetch and byte-loader bundle for the loadable instruction memory.
// master: core/host side; slave: memory side.
interface imem_prog_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [N-1:0]      fetch_q;
    logic              ld_start;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_ready;
    logic              ld_end;
    logic              ld_busy;
    logic [ADDR_W:0]   ld_count;
    logic              ld_ovf;

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_ready, fetch_valid, fetch_q,
        output ld_start, ld_valid, ld_byte, ld_end,
        input  ld_ready, ld_busy, ld_count, ld_ovf
    );

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_ready, fetch_valid, fetch_q,
        input  ld_start, ld_valid, ld_byte, ld_end,
        output ld_ready, ld_busy, ld_count, ld_ovf
    );
endinterface

// File: rtl/imem_prog.sv
// Loadable instruction memory: registered word fetch, byte-serial loader.
// Ports: clk, reset (async active-low), bus (imem_prog_if.slave).
module imem_prog #(
    parameter int N      = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic         clk,
    input  logic         reset,
    imem_prog_if.slave   bus
);
    localparam int LANES = N / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [LW-1:0]   LAST_C  = LW'(LANES - 1);

    typedef enum logic {RUN, LOAD} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [N-1:0]      word_q, word_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              valid_q;
    logic [N-1:0]      q_q;
    logic [N-1:0]      mem_q [DEPTH];

    logic              fetch_fire;
    logic              byte_fire;
    logic              in_range;
    logic              we;
    logic [ADDR_W:0]   waddr;
    logic [N-1:0]      wdata;
    logic [N-1:0]      wword;

    assign bus.fetch_ready = (state_q == RUN);
    assign bus.ld_busy     = (state_q == LOAD);
    assign bus.ld_ready    = (state_q == LOAD) && (count_q < DEPTH_C);
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_q     = q_q;
    assign bus.ld_count    = count_q;
    assign bus.ld_ovf      = ovf_q;

    assign fetch_fire = bus.fetch_req && bus.fetch_ready;
    assign byte_fire  = bus.ld_valid && bus.ld_ready;
    assign in_range   = ({1'b0, bus.fetch_addr} < DEPTH_C);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        waddr   = count_q;
        wdata   = word_q;
        wword   = word_q;
        unique case (state_q)
            RUN: begin
                if (bus.ld_start) begin
                    state_d = LOAD;
                    lane_d  = '0;
                    word_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (bus.ld_start) begin
                    lane_d  = '0;
                    word_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    if (byte_fire) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (lane_q == LW'(k)) begin
                                wword[8*k +: 8] = bus.ld_byte;
                            end
                        end
                        if (lane_q == LAST_C) begin
                            we      = 1'b1;
                            wdata   = wword;
                            count_d = count_q + 1'b1;
                            lane_d  = '0;
                            word_d  = '0;
                        end else begin
                            lane_d = lane_q + 1'b1;
                            word_d = wword;
                        end
                    end else if (bus.ld_valid) begin
                        // Only reachable when the memory is full.
                        ovf_d = 1'b1;
                    end
                    // Unfilled lanes are already zero, so the flush
                    // writes a zero-padded word.
                    if (bus.ld_end) begin
                        state_d = RUN;
                        if (lane_d != '0) begin
                            we      = 1'b1;
                            wdata   = word_d;
                            count_d = count_d + 1'b1;
                            lane_d  = '0;
                            word_d  = '0;
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            lane_q  <= '0;
            word_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            q_q     <= '0;
        end else if (fetch_fire) begin
            valid_q <= 1'b1;
            q_q     <= in_range ? mem_q[bus.fetch_addr[AW-1:0]] : '0;
        end else begin
            valid_q <= 1'b0;
        end
    end

    // Array is deliberately not reset so words survive a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: doc/imem_prog.md
Name: imem_prog

Overview:
- Parametrised, loadable instruction memory for the LEGv8 single-cycle/pipelined core. Replaces the fixed combinational ROM.
- Word-indexed fetch port with a registered read and a ready/valid handshake.
- Byte-serial loader port writes program words sequentially from address 0, so programs can be loaded at run time without re-synthesis.
- Sits between the fetch stage (PC word index) and a host/UART loader.

Parameters:
- N, 32, instruction word width in bits. Must be a multiple of 8.
- ADDR_W, 6, fetch address width (word index).
- DEPTH, 64, number of implemented words, with DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  word index to fetch.
- fetch_ready  out  1  fetch port accepting requests.
- fetch_valid  out  1  fetch_q holds the data for the last accepted request.
- fetch_q  out  N  fetched instruction.
- ld_start  in  1  one-cycle pulse that starts a load session.
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  program byte; little-endian within each word.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_end  in  1  one-cycle pulse that ends the load session.
- ld_busy  out  1  load session active.
- ld_count  out  ADDR_W+1  number of words written in the current or last session.
- ld_ovf  out  1  sticky flag: a byte was offered after memory was full.

Behaviour:
- Reset values (reset=0): state RUN, fetch_valid=0, fetch_q=0, ld_busy=0, ld_count=0, ld_ovf=0, byte lane=0, partial word cleared.
- Memory array is not reset. It powers up all zeros. Reset mid-load discards the partial word but keeps already-written words.
- States:
  - RUN: fetch_ready=1, ld_ready=0. ld_start moves to LOAD next cycle and clears ld_count, ld_ovf, lane and partial word.
  - LOAD: fetch_ready=0, ld_busy=1, ld_ready = (ld_count < DEPTH). ld_end moves to RUN.
- Fetch:
  - A request is accepted when fetch_req and fetch_ready are both 1.
  - Next cycle: fetch_q = mem[fetch_addr] and fetch_valid=1. Latency is exactly 1 cycle; back-to-back requests give one result per cycle.
  - If fetch_addr >= DEPTH, fetch_q=0.
  - No accepted request: fetch_valid=0 and fetch_q holds its last value.
- Fetch and ld_start in the same cycle: the fetch is accepted and served, and the state enters LOAD.
- Load:
  - Each byte is accepted when ld_valid and ld_ready are both 1. It is placed in lane k at bits [8k+7:8k], then k increments.
  - When lane N/8-1 is filled: write mem[ld_count] in that same edge, ld_count+1, k=0.
  - When ld_count = DEPTH: ld_ready=0. A byte offered with ld_valid sets ld_ovf and is dropped.
- ld_end:
  - With k != 0, the partial word is zero-padded and written to mem[ld_count], and ld_count increments.
  - ld_end together with an accepted ld_valid byte: the byte is absorbed first, then the flush above is applied in the same edge.
  - ld_end in RUN is ignored.
- ld_start while in LOAD restarts the session: ld_count=0, partial word discarded, ld_ovf cleared.
- Write-to-read hazard is impossible because fetch is blocked during LOAD. The first fetch after LOAD sees the new contents.
- ld_count and ld_ovf hold after the session ends until the next ld_start or reset.

Test Plan:
1. Reset, then fetch addr 0..3 back-to-back -> fetch_valid=1 from cycle 1, fetch_q=0 each cycle; fetch_addr=63 with DEPTH=48 -> fetch_q=0.
2. ld_start, then bytes 01 00 00 F8, 02 80 00 F8, then ld_end -> ld_count=2; fetch 0 -> 32'hF8000001, fetch 1 -> 32'hF8008002.
3. Load 6 bytes AA BB CC DD 11 22 and assert ld_end on the cycle of byte 22 -> mem[1]=32'h00002211, ld_count=2.
4. DEPTH=4: stream 20 bytes -> ld_ready drops after 16, ld_ovf=1, ld_count=4, mem[3] holds bytes 13..16.
5. Assert reset after 2 words and 2 bytes of a load -> state RUN, ld_count=0; mem[0], mem[1] retained; mem[2] unchanged.
6. fetch_req and ld_start in the same cycle -> fetch_valid=1 next cycle with correct data, fetch_ready=0 during LOAD; ld_start again mid-load -> ld_count=0 and the partial word is lost.
